dmem: RTL and testbench

Single-port-pair data memory for the synapse32 core's memory stage. It provides one synchronous write port and one synchronous read port on a shared clock, each with its own 32-bit word address and enable. Storage is a register array that is cleared on reset. Read data is registered.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem.sv | 69 ++++++
 tb/tb_dmem.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the synapse32 data memory.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int DMEM_DEFAULT_DEPTH = 64;

  typedef logic [DATA_W-1:0] dmem_word_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide register file: async clear, one sync write port,
// one combinational read of an index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  dmem_word_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output dmem_word_t    rdata_o
);

  dmem_word_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem.sv
// Data memory for the memory stage: word addressing, registered read.
// Define DMEM_BYPASS_EN for write-first behaviour on same-address collisions.
module dmem
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read,
  input  logic [31:0] write,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] in_data,
  output logic [31:0] out_data
);

  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  dmem_word_t    rdata;
  dmem_word_t    out_d;
  dmem_word_t    out_q;
  logic          unused_hi;

  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  assign ridx      = read[AW-1:0];
  assign widx      = write[AW-1:0];
  assign unused_hi = ^{read[31:AW], write[31:AW]};

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (wr_en),
    .waddr_i (widx),
    .wdata_i (in_data),
    .raddr_i (ridx),
    .rdata_o (rdata)
  );

  always_comb begin
    out_d = out_q;
    if (rd_en) begin
`ifdef DMEM_BYPASS_EN
      if (wr_en && (ridx == widx)) begin
        out_d = in_data;
      end else begin
        out_d = rdata;
      end
`else
      out_d = rdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_dmem.sv
// Scoreboard bench for dmem; expected read data comes from a
// reference array updated as stimulus is driven.
module tb_dmem;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] read;
  logic [31:0] write;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] in_data;
  logic [31:0] out_data;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_out;
  logic [31:0] sb [$];
  int          n_tests;
  int          n_fail;

  dmem #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .in_data  (in_data),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_out = '0;
    sb.delete();
  endtask

  // Drive one cycle, predict, then compare one cycle later.
  task automatic step(input string tag, input logic re,
                      input logic [31:0] ra, input logic we,
                      input logic [31:0] wa, input logic [31:0] d);
    logic [AW-1:0] ri;
    logic [AW-1:0] wi;
    ri      = ra[AW-1:0];
    wi      = wa[AW-1:0];
    rd_en   = re;
    read    = ra;
    wr_en   = we;
    write   = wa;
    in_data = d;
    if (re) begin
`ifdef DMEM_BYPASS_EN
      if (we && (ri == wi)) exp_out = d;
      else exp_out = model[ri];
`else
      exp_out = model[ri];
`endif
    end
    sb.push_back(exp_out);
    if (we) model[wi] = d;
    @(posedge clk);
    #1;
    if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, out_data, sb.pop_front());
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    read    = '0;
    write   = '0;
    in_data = '0;
    rst_n   = 1'b0;
    model_clear();
    #12;
    check("reset_out", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill nonzero data, then reset and confirm clear.
    step("pre_w0", 1'b0, 0, 1'b1, 0, 32'h1111_0000);
    step("pre_w1", 1'b0, 0, 1'b1, 1, 32'h2222_0001);
    step("pre_w2", 1'b0, 0, 1'b1, 2, 32'h3333_0002);
    step("pre_r1", 1'b1, 1, 1'b0, 0, 0);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst_out", out_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_r0", 1'b1, 0, 1'b0, 0, 0);
    step("rst_r1", 1'b1, 1, 1'b0, 0, 0);
    step("rst_r2", 1'b1, 2, 1'b0, 0, 0);

    // Writes with no read keep out_data at 0.
    for (int i = 0; i < 5; i++) step("wr_noread", 1'b0, 0, 1'b1, 2, 3);
    step("rd_after_wr", 1'b1, 2, 1'b0, 0, 0);

    // Concurrent access to different addresses.
    step("conc_r1", 1'b1, 1, 1'b1, 2, 2);
    step("conc_r2", 1'b1, 2, 1'b0, 0, 0);

    // Disabled write leaves memory alone.
    step("wdis_r1", 1'b1, 1, 1'b0, 1, 4);
    step("wdis_r1b", 1'b1, 1, 1'b0, 0, 0);

    // Same-address collision.
    step("col_pre", 1'b0, 0, 1'b1, 5, 7);
    step("col_rw", 1'b1, 5, 1'b1, 5, 9);
    step("col_after", 1'b1, 5, 1'b0, 0, 0);

    // Address wrap and read hold.
    step("wrap_w", 1'b0, 0, 1'b1, DEPTH + 3, 32'hDEAD_BEEF);
    step("wrap_r", 1'b1, 3, 1'b0, 0, 0);
    step("hold", 1'b0, 7, 1'b0, 0, 0);
    step("wrap_rhi", 1'b1, 32'hFFFF_FFC3, 1'b0, 0, 0);

    // Mixed traffic over a small address window to force collisions.
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) | 32'($urandom) << 6,
           32'($urandom));
    end

    // Reset mid-operation discards the write on that edge.
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    write   = 6;
    in_data = 32'hABCD_0123;
    rst_n   = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("rst_mid_out", out_data, 32'h0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_mid_r6", 1'b1, 6, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
